// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encodings and counter sizing.
package btn_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;

    // Bits needed to hold 0..max_val; never less than one so a zero limit still yields a legal vector.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One push-button channel: 2-flop synchroniser, debounce, press/hold/repeat FSM and registered event pulses.
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = 4,
    parameter int unsigned HOLD_CYCLES   = 1000,
    parameter int unsigned REPEAT_CYCLES = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_i,
    output logic level_o,
    output logic press_o,
    output logic rel_o,
    output logic hold_o,
    output logic rpt_o
);

    localparam int unsigned DBW = cnt_width(DB_CYCLES);
    localparam int unsigned HW  = cnt_width(HOLD_CYCLES);
    localparam int unsigned RW  = cnt_width(REPEAT_CYCLES);

    localparam logic [DBW-1:0] DB_MAX    = DBW'(DB_CYCLES);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0]  RPT_LAST  = RW'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);

    logic           sync1_q, sync2_q;
    logic           level_q, level_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]     state_q, state_d;
    logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [RW-1:0]  rpt_cnt_q, rpt_cnt_d;
    logic           press_q, press_d;
    logic           rel_q, rel_d;
    logic           hold_q, hold_d;
    logic           rpt_q, rpt_d;

    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        // Toggle happens on the edge after the counter has reached the limit, clearing it at that edge.
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_MAX) begin
                level_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + DBW'(1);
            end
        end

        press_d = level_d & ~level_q;
        rel_d   = ~level_d & level_q;

        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rpt_cnt_d  = rpt_cnt_q;
        hold_d     = 1'b0;
        rpt_d      = 1'b0;

        // An accepted fall always wins, so hold/repeat events never share a cycle with rel.
        case (state_q)
            ST_IDLE: begin
                if (press_d) begin
                    state_d    = ST_PRESSED;
                    hold_cnt_d = '0;
                end
            end
            ST_PRESSED: begin
                if (rel_d) begin
                    state_d = ST_IDLE;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    hold_d    = 1'b1;
                    state_d   = ST_HELD;
                    rpt_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            ST_HELD: begin
                if (rel_d) begin
                    state_d = ST_IDLE;
                end else if (REPEAT_CYCLES != 0) begin
                    if (rpt_cnt_q == RPT_LAST) begin
                        rpt_d     = 1'b1;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            level_q    <= 1'b0;
            db_cnt_q   <= '0;
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            rpt_cnt_q  <= '0;
            press_q    <= 1'b0;
            rel_q      <= 1'b0;
            hold_q     <= 1'b0;
            rpt_q      <= 1'b0;
        end else begin
            sync1_q    <= pb_i;
            sync2_q    <= sync1_q;
            level_q    <= level_d;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rpt_cnt_q  <= rpt_cnt_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
            hold_q     <= hold_d;
            rpt_q      <= rpt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;
    assign rel_o   = rel_q;
    assign hold_o  = hold_q;
    assign rpt_o   = rpt_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: one independent btn_channel per input bit.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned DB_CYCLES     = 4,
    parameter int unsigned HOLD_CYCLES   = 1000,
    parameter int unsigned REPEAT_CYCLES = 250
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] pb,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] rel_pulse,
    output logic [N_CH-1:0] hold_pulse,
    output logic [N_CH-1:0] rpt_pulse
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_channel #(
            .DB_CYCLES    (DB_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .pb_i   (pb[i]),
            .level_o(level[i]),
            .press_o(press_pulse[i]),
            .rel_o  (rel_pulse[i]),
            .hold_o (hold_pulse[i]),
            .rpt_o  (rpt_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: two builds (auto-repeat every 5 cycles, and repeat disabled).
module tb_button_conditioner;

    logic       clk;
    logic       rst;
    logic [1:0] pb;
    logic [1:0] level, press_pulse, rel_pulse, hold_pulse, rpt_pulse;
    logic [1:0] pb_nr;
    logic [1:0] level_nr, press_nr, rel_nr, hold_nr, rpt_nr;

    int unsigned pass_cnt;
    int unsigned chk_cnt;

    button_conditioner #(
        .N_CH         (2),
        .DB_CYCLES    (4),
        .HOLD_CYCLES  (20),
        .REPEAT_CYCLES(5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pb         (pb),
        .level      (level),
        .press_pulse(press_pulse),
        .rel_pulse  (rel_pulse),
        .hold_pulse (hold_pulse),
        .rpt_pulse  (rpt_pulse)
    );

    button_conditioner #(
        .N_CH         (2),
        .DB_CYCLES    (4),
        .HOLD_CYCLES  (20),
        .REPEAT_CYCLES(0)
    ) dut_nr (
        .clk        (clk),
        .rst        (rst),
        .pb         (pb_nr),
        .level      (level_nr),
        .press_pulse(press_nr),
        .rel_pulse  (rel_nr),
        .hold_pulse (hold_nr),
        .rpt_pulse  (rpt_nr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pb = 2'b11;
        pb_nr = 2'b11;
        #1;
        chk_cnt++;
        if ({level, press_pulse, rel_pulse, hold_pulse, rpt_pulse} !== 10'b0) begin
            $display("FAIL reset_async got=%b exp=%b", {level, press_pulse, rel_pulse, hold_pulse, rpt_pulse}, 10'b0);
        end else pass_cnt++;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk_cnt++;
            if ({level, press_pulse, rel_pulse, hold_pulse, rpt_pulse, level_nr, press_nr, rel_nr, hold_nr, rpt_nr} !== 20'b0) begin
                $display("FAIL reset_hold k=%0d got=%b/%b exp=0", k,
                         {level, press_pulse, rel_pulse, hold_pulse, rpt_pulse},
                         {level_nr, press_nr, rel_nr, hold_nr, rpt_nr});
            end else pass_cnt++;
        end
        pb = 2'b00;
        pb_nr = 2'b00;
        step();
        rst = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_press_release();
        logic [1:0] e_lv, e_pr, e_rl;
        pb = 2'b01;
        for (int k = 1; k <= 9; k++) begin
            step();
            e_lv = (k >= 7) ? 2'b01 : 2'b00;
            e_pr = (k == 7) ? 2'b01 : 2'b00;
            chk_cnt++;
            if ({level, press_pulse, rel_pulse, hold_pulse, rpt_pulse} !== {e_lv, e_pr, 6'b0}) begin
                $display("FAIL press k=%0d got=%b exp=%b", k,
                         {level, press_pulse, rel_pulse, hold_pulse, rpt_pulse}, {e_lv, e_pr, 6'b0});
            end else pass_cnt++;
        end
        pb = 2'b00;
        for (int k = 1; k <= 9; k++) begin
            step();
            e_lv = (k >= 7) ? 2'b00 : 2'b01;
            e_rl = (k == 7) ? 2'b01 : 2'b00;
            chk_cnt++;
            if ({level, press_pulse, rel_pulse, hold_pulse, rpt_pulse} !== {e_lv, 2'b0, e_rl, 4'b0}) begin
                $display("FAIL release k=%0d got=%b exp=%b", k,
                         {level, press_pulse, rel_pulse, hold_pulse, rpt_pulse}, {e_lv, 2'b0, e_rl, 4'b0});
            end else pass_cnt++;
        end
        repeat (5) step();
    endtask

    task automatic test_bounce();
        pb = 2'b01;
        for (int k = 1; k <= 15; k++) begin
            if (k == 4) pb = 2'b00;
            step();
            chk_cnt++;
            if ({level, press_pulse, rel_pulse, hold_pulse, rpt_pulse} !== 10'b0) begin
                $display("FAIL bounce k=%0d got=%b exp=%b", k,
                         {level, press_pulse, rel_pulse, hold_pulse, rpt_pulse}, 10'b0);
            end else pass_cnt++;
        end
        repeat (5) step();
    endtask

    task automatic test_hold_repeat();
        logic [1:0] e_lv, e_pr, e_rl, e_hd, e_rp;
        // pb[1] sampled high on edges 1..40: press@7, hold@27, repeats @32/37/42, fall@47 swallows the @47 repeat.
        pb = 2'b10;
        for (int k = 1; k <= 60; k++) begin
            step();
            e_lv = (k >= 7 && k < 47) ? 2'b10 : 2'b00;
            e_pr = (k == 7) ? 2'b10 : 2'b00;
            e_hd = (k == 27) ? 2'b10 : 2'b00;
            e_rp = (k == 32 || k == 37 || k == 42) ? 2'b10 : 2'b00;
            e_rl = (k == 47) ? 2'b10 : 2'b00;
            chk_cnt++;
            if ({level, press_pulse, rel_pulse, hold_pulse, rpt_pulse} !== {e_lv, e_pr, e_rl, e_hd, e_rp}) begin
                $display("FAIL hold_repeat k=%0d got=%b exp=%b", k,
                         {level, press_pulse, rel_pulse, hold_pulse, rpt_pulse}, {e_lv, e_pr, e_rl, e_hd, e_rp});
            end else pass_cnt++;
            if (k == 40) pb = 2'b00;
        end
        repeat (5) step();
    endtask

    task automatic test_short_release();
        logic [1:0] e_lv, e_pr, e_rl;
        // hi=19: fall 19 cycles after press; hi=20: fall lands on the edge the hold event would have fired.
        for (int hi = 19; hi <= 20; hi++) begin
            pb = 2'b01;
            for (int k = 1; k <= 40; k++) begin
                step();
                e_lv = (k >= 7 && k < hi + 7) ? 2'b01 : 2'b00;
                e_pr = (k == 7) ? 2'b01 : 2'b00;
                e_rl = (k == hi + 7) ? 2'b01 : 2'b00;
                chk_cnt++;
                if ({level, press_pulse, rel_pulse, hold_pulse, rpt_pulse} !== {e_lv, e_pr, e_rl, 4'b0}) begin
                    $display("FAIL short_release hi=%0d k=%0d got=%b exp=%b", hi, k,
                             {level, press_pulse, rel_pulse, hold_pulse, rpt_pulse}, {e_lv, e_pr, e_rl, 4'b0});
                end else pass_cnt++;
                if (k == hi) pb = 2'b00;
            end
            repeat (5) step();
        end
    endtask

    task automatic test_reset_in_held();
        logic [1:0] e_lv, e_pr;
        pb = 2'b10;
        repeat (30) step();
        chk_cnt++;
        if (level !== 2'b10) begin
            $display("FAIL pre_reset_level got=%b exp=%b", level, 2'b10);
        end else pass_cnt++;
        rst = 1'b1;
        #1;
        chk_cnt++;
        if ({level, press_pulse, rel_pulse, hold_pulse, rpt_pulse} !== 10'b0) begin
            $display("FAIL reset_in_held_async got=%b exp=%b",
                     {level, press_pulse, rel_pulse, hold_pulse, rpt_pulse}, 10'b0);
        end else pass_cnt++;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk_cnt++;
            if ({level, press_pulse, rel_pulse, hold_pulse, rpt_pulse} !== 10'b0) begin
                $display("FAIL reset_in_held k=%0d got=%b exp=%b", k,
                         {level, press_pulse, rel_pulse, hold_pulse, rpt_pulse}, 10'b0);
            end else pass_cnt++;
        end
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            e_lv = (k >= 7) ? 2'b10 : 2'b00;
            e_pr = (k == 7) ? 2'b10 : 2'b00;
            chk_cnt++;
            if ({level, press_pulse, rel_pulse, hold_pulse, rpt_pulse} !== {e_lv, e_pr, 6'b0}) begin
                $display("FAIL post_reset_press k=%0d got=%b exp=%b", k,
                         {level, press_pulse, rel_pulse, hold_pulse, rpt_pulse}, {e_lv, e_pr, 6'b0});
            end else pass_cnt++;
        end
        pb = 2'b00;
        repeat (15) step();
    endtask

    task automatic test_no_repeat();
        logic [1:0] e_lv, e_pr, e_rl, e_hd;
        pb_nr = 2'b01;
        for (int k = 1; k <= 80; k++) begin
            step();
            e_lv = (k >= 7 && k < 67) ? 2'b01 : 2'b00;
            e_pr = (k == 7) ? 2'b01 : 2'b00;
            e_hd = (k == 27) ? 2'b01 : 2'b00;
            e_rl = (k == 67) ? 2'b01 : 2'b00;
            chk_cnt++;
            if ({level_nr, press_nr, rel_nr, hold_nr, rpt_nr} !== {e_lv, e_pr, e_rl, e_hd, 2'b00}) begin
                $display("FAIL no_repeat k=%0d got=%b exp=%b", k,
                         {level_nr, press_nr, rel_nr, hold_nr, rpt_nr}, {e_lv, e_pr, e_rl, e_hd, 2'b00});
            end else pass_cnt++;
            if (k == 60) pb_nr = 2'b00;
        end
        repeat (5) step();
    endtask

    initial begin
        pass_cnt = 0;
        chk_cnt  = 0;
        rst      = 1'b1;
        pb       = 2'b00;
        pb_nr    = 2'b00;
        test_reset();
        test_press_release();
        test_bounce();
        test_hold_repeat();
        test_short_release();
        test_reset_in_held();
        test_no_repeat();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
